muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 The block SHALL provide clk  input  1  rising-edge clock shared with the pipeline registers.
REQ-003 The block SHALL provide rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL provide start  input  1  issue strobe from the EX stage for a MULT/MULTU/DIV/DIVU instruction.
REQ-005 The block SHALL provide op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL provide src_a  input  32  rs operand (multiplicand or dividend).
REQ-007 The block SHALL provide src_b  input  32  rt operand (multiplier or divisor).
REQ-008 The block SHALL provide mthi  input  1, mtlo  input  1 and wdata  input  32 for direct HI/LO writes.
REQ-009 The block SHALL provide flush  input  1  abort request, driven from the pipeline branch-taken flush.
REQ-010 The block SHALL provide busy  output  1  stall request to the hazard unit.
REQ-011 The block SHALL provide done  output  1  one-cycle completion pulse.
REQ-012 The block SHALL provide hi  output  32 and lo  output  32, the registered HI and LO values.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE; busy=1 exactly in MUL and DIV; done=1 exactly in DONE.
REQ-014 In IDLE or DONE, start=1 with flush=0 SHALL latch op, src_a and src_b, clear the iteration counter, and enter MUL (op[1]=0) or DIV (op[1]=1) on that edge.
REQ-015 For signed ops, the block SHALL iterate on the absolute values and record the result signs at start.
REQ-016 MUL SHALL be radix-2 shift-add and DIV SHALL be restoring, one iteration per cycle, with a 5-bit counter covering exactly 32 iterations.
REQ-017 On the edge of iteration 32, the block SHALL write HI/LO with the sign-corrected result and enter DONE: latency is start edge E0 -> busy during cycles after E0..E31 -> HI/LO updated at E32, with done=1 in the following cycle.
REQ-018 For MULT/MULTU, the block SHALL set HI:LO to the 64-bit product, signed or unsigned per op.
REQ-019 For DIV/DIVU, the block SHALL set LO=quotient and HI=remainder; for DIV the quotient is negative iff the operand signs differ and the remainder takes the dividend's sign.
REQ-020 For division by zero (DIV or DIVU), the block SHALL set HI=src_a and LO=32'hFFFFFFFF after the normal 32-cycle latency.
REQ-021 For DIV 32'h80000000 / 32'hFFFFFFFF, the block SHALL set LO=32'h80000000 and HI=0 (two's-complement wrap), with no exception.
REQ-022 From DONE with no accepted start, the block SHALL return to IDLE on the next edge; a start accepted in DONE proceeds back-to-back.
REQ-023 In MUL or DIV, the block SHALL ignore start.
REQ-024 In MUL or DIV, flush=1 SHALL abort to IDLE on that edge, leave HI/LO unchanged and produce no done pulse.
REQ-025 If flush=1 and start=1 arrive together in IDLE or DONE, the block SHALL ignore start.
REQ-026 In IDLE or DONE with start=0, mthi SHALL write wdata to HI and mtlo SHALL write wdata to LO on the edge; both may occur together.
REQ-027 When busy=1, or when start is accepted in the same cycle, the block SHALL ignore mthi and mtlo.
REQ-028 The hi and lo outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-029 When rst=1 at an edge, the block SHALL set state=IDLE, HI=0, LO=0, counter=0, busy=0 and done=0, overriding start, flush, mthi and mtlo.
REQ-030 Reset asserted mid-operation SHALL discard the operation without producing a done pulse.

Verification
REQ-031 MULT src_a=32'hFFFFFFFD, src_b=7 -> busy for 32 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB and done high for exactly 1 cycle.
REQ-032 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001; a back-to-back start in the DONE cycle raises busy on the next cycle.
REQ-033 DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 100/0 -> HI=32'h64, LO=32'hFFFFFFFF.
REQ-034 DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-035 Preload HI=LO=32'h5 via mthi/mtlo, start MULT, flush in busy cycle 10 -> busy=0 the next cycle, HI=LO=32'h5, no done; repeat with rst instead -> HI=LO=0.
REQ-036 mthi during busy -> HI unchanged; start and mtlo in the same IDLE cycle -> LO unchanged until the result arrives; mtlo alone in IDLE -> LO=wdata after one edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for MULT/MULTU/DIV/DIVU.
// A radix-2 shift-add multiply or restoring divide runs one iteration per cycle
// for 32 cycles on operand magnitudes; the result sign is fixed up on the last edge.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op[1:0]     issue strobe; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b       rs (multiplicand/dividend), rt (multiplier/divisor)
//   mthi, mtlo, wdata  direct HI/LO writes while the unit is not busy
//   flush              aborts an operation in flight
//   busy, done         stall request; one-cycle completion pulse
//   hi, lo             registered HI/LO
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_mc;        // multiplicand or divisor magnitude
  logic [31:0] r_ph, r_pl;  // MUL: product high/low; DIV: remainder / dividend->quotient
  logic [31:0] r_src_a;     // raw dividend, returned in HI on divide-by-zero
  logic        r_neg_q, r_neg_r, r_dz;

  logic        w_accept, w_run, w_last;
  logic        w_sa, w_sb;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_sum, w_rsh;
  logic [31:0] w_sub;
  logic        w_ge;
  logic [31:0] w_nh, w_nl;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_accept = (r_state == IDLE || r_state == DONE) && start && !flush;
  assign w_run    = (r_state == MUL || r_state == DIV);
  assign w_last   = (r_cnt == 5'd31);

  // Signed ops record operand signs and iterate on magnitudes.
  assign w_sa    = !op[0] && src_a[31];
  assign w_sb    = !op[0] && src_b[31];
  assign w_abs_a = w_sa ? (~src_a + 32'd1) : src_a;
  assign w_abs_b = w_sb ? (~src_b + 32'd1) : src_b;

  // One iteration step for either operation.
  always_comb begin
    w_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_mc} : 33'd0);
    w_rsh = {r_ph, r_pl[31]};
    w_ge  = (w_rsh >= {1'b0, r_mc});
    // Only used when w_ge, where the true difference fits in 32 bits.
    w_sub = w_rsh[31:0] - r_mc;
    if (r_state == DIV) begin
      w_nh = w_ge ? w_sub : w_rsh[31:0];
      w_nl = {r_pl[30:0], w_ge};
    end else begin
      w_nh = w_sum[32:1];
      w_nl = {w_sum[0], r_pl[31:1]};
    end
  end

  // Sign correction of the final iteration's result.
  always_comb begin
    w_prod = r_neg_q ? (64'd0 - {w_nh, w_nl}) : {w_nh, w_nl};
    if (r_state == DIV) begin
      if (r_dz) begin
        w_res_hi = r_src_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = r_neg_r ? (32'd0 - w_nh) : w_nh;
        w_res_lo = r_neg_q ? (32'd0 - w_nl) : w_nl;
      end
    end else begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done   = (r_state == DONE);
        w_next = IDLE;
        if (w_accept) w_next = op[1] ? DIV : MUL;
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (flush)       w_next = IDLE;
        else if (w_last) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_mc    <= 32'd0;
      r_ph    <= 32'd0;
      r_pl    <= 32'd0;
      r_src_a <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= 5'd0;
        r_ph    <= 32'd0;
        r_mc    <= op[1] ? w_abs_b : w_abs_a;
        r_pl    <= op[1] ? w_abs_a : w_abs_b;
        r_src_a <= src_a;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_dz    <= op[1] && (src_b == 32'd0);
      end else if (w_run) begin
        if (!flush) begin
          r_cnt <= r_cnt + 5'd1;
          r_ph  <= w_nh;
          r_pl  <= w_nl;
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
      end else if (!start) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {HI,LO} on each
// issued operation; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no outstanding op", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; holds start for one edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] e);
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (push) exp_q.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e);
    int n;
    issue(o, a, b, 1'b1, e);
    wait_idle(n);
    chk({name, "_busy_cycles"}, 64'(n), 64'd32);
    chk({name, "_done"}, 64'(done), 64'd1);
    step();
    chk({name, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    step(); step();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("mult_negneg", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0, 32'h1});
    run_op("multu_16", MULTU, 32'h0001_0000, 32'h0001_0000, {32'h1, 32'h0});

    // Back-to-back: next start issued in the DONE cycle.
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFE, 32'h0000_0001});
    wait_idle(n);
    chk("b2b_busy_cycles", 64'(n), 64'd32);
    chk("b2b_done", 64'(done), 64'd1);
    issue(DIVU, 32'd100, 32'd0, 1'b1, {32'h64, 32'hFFFF_FFFF});
    chk("b2b_busy_next", 64'(busy), 64'd1);
    wait_idle(n);
    chk("b2b2_busy_cycles", 64'(n), 64'd32);
    step();

    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op("div_zero_s", DIV, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'd10, {32'h5, 32'h1999_9999});

    // start together with flush in IDLE is ignored.
    op = MULT; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("start_flush_ignored", 64'(busy), 64'd0);

    // Preload, then flush in busy cycle 10.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("preload", {hi, lo}, {32'h5, 32'h5});
    issue(MULT, 32'd3, 32'd4, 1'b0, 64'd0);
    for (int i = 0; i < 9; i++) step();
    chk("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h5, 32'h5});
    for (int i = 0; i < 40; i++) step();

    // Same with reset instead of flush.
    issue(MULT, 32'd3, 32'd4, 1'b0, 64'd0);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 40; i++) step();

    // mthi while busy is ignored.
    issue(MULT, 32'd2, 32'd3, 1'b1, {32'h0, 32'h6});
    for (int i = 0; i < 4; i++) step();
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    mthi = 1'b0;
    chk("mthi_busy_ignored", 64'(hi), 64'd0);
    wait_idle(n);
    step();

    // mtlo in the same cycle as an accepted start is ignored.
    mtlo = 1'b1; wdata = 32'h1234;
    issue(MULTU, 32'd5, 32'd5, 1'b1, {32'h0, 32'd25});
    mtlo = 1'b0;
    chk("mtlo_with_start", 64'(lo), 64'd6);
    wait_idle(n);
    step();

    // mtlo alone in IDLE.
    mtlo = 1'b1; wdata = 32'hABCD;
    step();
    mtlo = 1'b0;
    chk("mtlo_idle", {hi, lo}, {32'h0, 32'hABCD});

    for (int i = 0; i < 3; i++) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
